digit_serial_addsub: RTL
========================

# digit_serial_addsub

Parametrised, multi-cycle N-bit two's-complement adder/subtractor that processes operands K bits per clock, least-significant digit first. It is the sequential successor to the team's combinational N-bit ripple subtractor. It adds an add/sub mode, a start/done handshake and a full registered N/Z/C/V flag set. It sits between the operand registers and the ALU result/flag bus, trading latency for a K-bit carry chain.

## Interface
- `N`, default 8: operand/result width; must be a multiple of `K`.
- `K`, default 2: digit width processed per cycle; 1 ≤ `K` ≤ `N`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when idle or done.
- `op`  in  1  0 = add (A+B), 1 = subtract (A−B); latched with start.
- `A`  in  N  first operand / minuend; latched with start.
- `B`  in  N  second operand / subtrahend; latched with start.
- `busy`  out  1  high while digits are being processed.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `R`  out  N  result.
- `C`  out  1  add: carry-out; sub: borrow (1 when A < B unsigned).
- `V`  out  1  signed overflow.
- `Nf`  out  1  `R[N-1]`.
- `Z`  out  1  `R == 0`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after the last digit.
  - DONE → IDLE unconditionally, or DONE → RUN if `start` is high.
- Accept on start (IDLE or DONE):
  - latch `A` and the original `B`;
  - load the shift operand as `B` for add and `~B` for sub;
  - set carry to `op`;
  - set the digit counter to 0.
- RUN: each cycle, add digit `[K-1:0]` of the shift registers with the carry.
  - Shift the sum digit into the top of the result shift register.
  - Shift the operands right by K.
  - Update carry; increment the counter.
- Last digit is counter == N/K−1. On that edge:
  - `R` ← final result;
  - `C` ← carry_out for add, ~carry_out for sub;
  - `Nf` ← `R[N-1]`; `Z` ← (`R` == 0);
  - `V` add: ~(A[N-1]^B[N-1]) & (A[N-1]^R[N-1]);
  - `V` sub: (A[N-1]^B[N-1]) & (A[N-1]^R[N-1]), using latched original A/B.
- `R` and flags hold until the next completion; they do not change at accept.
- `busy` = (state == RUN). `done` = (state == DONE).
- `start` while RUN is ignored; no queuing.
- Changes to `A`/`B`/`op` after accept have no effect.
- All arithmetic is modulo 2^N; no width extension beyond the carry bit.

## Timing
- Reset: state IDLE; `busy`=0, `done`=0, `R`=0, `C`=0, `V`=0, `Nf`=0, `Z`=0.
- Counter, carry and shift registers are cleared on reset.
- Latency: accept edge E0; digits processed at E1..E(N/K); `done` is high in the cycle after E(N/K).
- Throughput: one operation per N/K+1 cycles. Back-to-back operation is possible via start-in-DONE.
- `N` == `K`: single RUN cycle; `done` in the cycle after E1.
- `rst` mid-RUN aborts: no `done`, and outputs return to reset values.
- `rst` and `start` on the same edge: `rst` wins.
- `start` in DONE: `done` still pulses that cycle; the new operation begins at that edge.

## Structure
- Package `addsub_pkg`:
  - state enum `addsub_state_t` {IDLE, RUN, DONE};
  - constants `OP_ADD`=1'b0, `OP_SUB`=1'b1.
- Sub-module `digit_adder #(K)`: combinational K-bit ripple full-adder chain (a, b, cin → s, cout), instantiated once.
- Top holds the FSM, counter (width $clog2(N/K)+1), shift registers and flag logic.

## Test plan
All cases use N=8, K=2 unless stated.
- Sub 8'h05−8'h03 → `R`=8'h02, `C`=0, `V`=0, `Nf`=0, `Z`=0. `done` pulses one cycle in the cycle after E4; `busy` is high for 4 cycles.
- Sub 8'h03−8'h05 → `R`=8'hFE, `C`=1, `Nf`=1, `V`=0. Sub 8'h80−8'h01 → `R`=8'h7F, `V`=1, `C`=0.
- Add 8'h7F+8'h01 → `R`=8'h80, `V`=1, `Nf`=1, `C`=0. Add 8'hFF+8'h01 → `R`=8'h00, `C`=1, `Z`=1, `V`=0.
- Handshake cases:
  - `start` pulsed during RUN with different A/B → ignored, and the original result is delivered.
  - A/B toggled mid-RUN → no effect.
  - `start` in the DONE cycle → second result, with `done` after another 4 digit cycles.
- Reset cases:
  - `rst` asserted in the 2nd RUN cycle → next cycle is IDLE with all outputs 0 and no `done`.
  - `rst`+`start` on the same edge → remains IDLE.
- Parameter sweep: K=8 (latency 1 digit cycle), K=1 (8 cycles), N=16/K=4. Compare 1000 random add/sub pairs against a reference model.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the op-select values.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/digit_adder.sv
// K-bit combinational ripple-carry adder; one digit of the serial datapath.
module digit_adder #(
  parameter int K = 2
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout
);

  logic [K:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_fa
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[K];

endmodule

// File: rtl/digit_serial_addsub.sv
// N-bit add/subtract processed K bits per clock, LSB digit first,
// with a start/done handshake and registered N/Z/C/V flags.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] R,
  output logic         C,
  output logic         V,
  output logic         Nf,
  output logic         Z
);

  localparam int DIGITS = N / K;
  localparam int CW     = $clog2(DIGITS) + 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  addsub_state_t state_reg, state_next;

  logic [CW-1:0] cnt_reg;
  logic          carry_reg;
  logic          op_reg;
  logic          a_msb_reg;
  logic          b_msb_reg;
  logic [N-1:0]  sa_reg;
  logic [N-1:0]  sb_reg;
  logic [N-1:0]  acc_reg;

  logic [N-1:0]  r_reg;
  logic          c_reg;
  logic          v_reg;
  logic          nf_reg;
  logic          z_reg;

  logic          accept;
  logic          last_digit;
  logic [K-1:0]  dsum;
  logic          dcout;
  logic [N-1:0]  acc_next;
  logic [N-1:0]  sa_next;
  logic [N-1:0]  sb_next;
  logic          c_fin;
  logic          v_fin;

  assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_digit = (cnt_reg == LAST_DIGIT);

  digit_adder #(.K(K)) u_adder (
    .a    (sa_reg[K-1:0]),
    .b    (sb_reg[K-1:0]),
    .cin  (carry_reg),
    .s    (dsum),
    .cout (dcout)
  );

  // Sum digit enters at the top; after N/K shifts the register holds the result.
  assign acc_next = N'({dsum, acc_reg} >> K);
  assign sa_next  = N'({{K{1'b0}}, sa_reg} >> K);
  assign sb_next  = N'({{K{1'b0}}, sb_reg} >> K);

  // Subtraction runs as A + ~B + 1, so the borrow is the inverted carry.
  assign c_fin = (op_reg == OP_SUB) ? ~dcout : dcout;
  assign v_fin = (op_reg == OP_SUB)
               ? ((a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ acc_next[N-1]))
               : (~(a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ acc_next[N-1]));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      op_reg    <= OP_ADD;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      sa_reg    <= '0;
      sb_reg    <= '0;
      acc_reg   <= '0;
      r_reg     <= '0;
      c_reg     <= 1'b0;
      v_reg     <= 1'b0;
      nf_reg    <= 1'b0;
      z_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg    <= op;
        a_msb_reg <= A[N-1];
        b_msb_reg <= B[N-1];
        sa_reg    <= A;
        sb_reg    <= (op == OP_SUB) ? ~B : B;
        carry_reg <= op;
        cnt_reg   <= '0;
        acc_reg   <= '0;
      end else if (state_reg == RUN) begin
        sa_reg    <= sa_next;
        sb_reg    <= sb_next;
        acc_reg   <= acc_next;
        carry_reg <= dcout;
        cnt_reg   <= cnt_reg + CW'(1);
        if (last_digit) begin
          r_reg  <= acc_next;
          c_reg  <= c_fin;
          v_reg  <= v_fin;
          nf_reg <= acc_next[N-1];
          z_reg  <= (acc_next == '0);
        end
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign R    = r_reg;
  assign C    = c_reg;
  assign V    = v_reg;
  assign Nf   = nf_reg;
  assign Z    = z_reg;

endmodule
